// File: rtl/steer_ctrl.sv
// Pan-servo steering sequencer: turns absolute CCR targets into one hold/dec/inc/center
// command per servo update period, tracking a shadow of the servo CCR.
module steer_ctrl #(
  parameter int unsigned UPDATE_CYCLES = 1080000,
  parameter int unsigned CCR_MIN       = 27000,
  parameter int unsigned CCR_MAX       = 54000,
  parameter int unsigned CCR_CENTER    = 40500,
  parameter int unsigned STEP          = 100,
  parameter int unsigned SETTLE_TICKS  = 5,
  parameter int unsigned IDLE_TICKS    = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tgt_valid,
  input  logic [20:0] tgt_ccr,
  output logic        tgt_ready,
  input  logic        center_req,
  output logic [1:0]  direct,
  output logic        busy,
  output logic [20:0] pos,
  output logic        at_target
);

  localparam int CNT_W = $clog2(UPDATE_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
  localparam int SET_W = $clog2(SETTLE_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(UPDATE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_TICKS);
  localparam logic [IDLE_W-1:0] IDLE_PRE   = IDLE_W'(IDLE_TICKS - 1);
  localparam logic [SET_W-1:0]  SET_LOAD   = SET_W'(SETTLE_TICKS);
  localparam logic [SET_W-1:0]  SET_ONE    = SET_W'(1);
  localparam logic [20:0]       MIN_C      = 21'(CCR_MIN);
  localparam logic [20:0]       MAX_C      = 21'(CCR_MAX);
  localparam logic [20:0]       CTR_C      = 21'(CCR_CENTER);
  localparam logic [20:0]       STEP_C     = 21'(STEP);
  localparam logic [20:0]       DEC_FLOOR  = 21'(CCR_MIN + STEP);
  localparam logic [20:0]       INC_CEIL   = 21'(CCR_MAX - STEP);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE, CENTER} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         direct_reg, direct_next;
  logic [20:0]        pos_reg, pos_next, pos_upd;
  logic [20:0]        tgt_reg, tgt_next, tgt_clamped;
  logic               at_target_reg, at_target_next;
  logic               ctr_pend_reg, ctr_pend_next;
  logic               ready_ok_reg;
  logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic               tick, accept, idle_expire;

  // Distance test written both ways round so the unsigned subtraction never wraps.
  function automatic logic far(input logic [20:0] a, input logic [20:0] b);
    return (a >= b) ? ((a - b) >= STEP_C) : ((b - a) >= STEP_C);
  endfunction

  assign tick      = (cnt_reg == CNT_LAST);
  assign tgt_ready = ready_ok_reg & ~ctr_pend_reg & (state_reg != CENTER);
  assign direct    = direct_reg;
  assign pos       = pos_reg;
  assign at_target = at_target_reg;
  assign busy      = (state_reg != IDLE);

  assign tgt_clamped = (tgt_ccr < MIN_C) ? MIN_C : ((tgt_ccr > MAX_C) ? MAX_C : tgt_ccr);

  // A pending center (explicit or timeout) takes priority over a target in the same cycle.
  assign idle_expire = tick & ~ctr_pend_reg & (state_reg == IDLE) & ~far(tgt_reg, pos_upd)
                     & (idle_cnt_reg == IDLE_PRE) & (pos_upd != CTR_C);
  assign accept = tgt_valid & tgt_ready & ~center_req & ~idle_expire;

  always_comb begin
    pos_upd = pos_reg;
    case (direct_reg)
      2'b01:   pos_upd = (pos_reg < DEC_FLOOR) ? MIN_C : pos_reg - STEP_C;
      2'b10:   pos_upd = (pos_reg > INC_CEIL) ? MAX_C : pos_reg + STEP_C;
      2'b11:   pos_upd = CTR_C;
      default: pos_upd = pos_reg;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    direct_next     = direct_reg;
    pos_next        = pos_reg;
    tgt_next        = accept ? tgt_clamped : tgt_reg;
    at_target_next  = at_target_reg;
    ctr_pend_next   = ctr_pend_reg;
    idle_cnt_next   = accept ? '0 : idle_cnt_reg;
    settle_cnt_next = settle_cnt_reg;

    if (tick) begin
      pos_next = pos_upd;
      if (ctr_pend_reg) begin
        state_next    = CENTER;
        direct_next   = 2'b11;
        ctr_pend_next = 1'b0;
      end else if (state_reg == CENTER) begin
        tgt_next        = CTR_C;
        direct_next     = 2'b00;
        state_next      = SETTLE;
        settle_cnt_next = SET_LOAD;
      end else if (far(tgt_reg, pos_upd)) begin
        state_next  = MOVE;
        direct_next = (tgt_reg > pos_upd) ? 2'b10 : 2'b01;
      end else begin
        direct_next = 2'b00;
        case (state_reg)
          MOVE: begin
            state_next      = SETTLE;
            settle_cnt_next = SET_LOAD;
          end
          SETTLE: begin
            if (settle_cnt_reg <= SET_ONE) begin
              settle_cnt_next = '0;
              state_next      = IDLE;
            end else begin
              settle_cnt_next = settle_cnt_reg - SET_ONE;
            end
          end
          default: begin
            // Counter holds at its limit once the servo already sits at center.
            if (!accept && idle_cnt_reg != IDLE_MAX)
              idle_cnt_next = idle_cnt_reg + 1'b1;
            if (idle_expire)
              ctr_pend_next = 1'b1;
          end
        endcase
      end
      if (state_next != IDLE)
        idle_cnt_next = '0;
      at_target_next = ~far(tgt_next, pos_next);
    end

    if (center_req)
      ctr_pend_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      direct_reg     <= 2'b00;
      pos_reg        <= CTR_C;
      tgt_reg        <= CTR_C;
      at_target_reg  <= 1'b1;
      ctr_pend_reg   <= 1'b0;
      ready_ok_reg   <= 1'b0;
      idle_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= tick ? '0 : cnt_reg + 1'b1;
      direct_reg     <= direct_next;
      pos_reg        <= pos_next;
      tgt_reg        <= tgt_next;
      at_target_reg  <= at_target_next;
      ctr_pend_reg   <= ctr_pend_next;
      ready_ok_reg   <= 1'b1;
      idle_cnt_reg   <= idle_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
    end
  end

endmodule
